// File: rtl/aim_noc_switch_allocator.sv
// 5x5 wormhole switch allocator: per-output round-robin locks held from head to tail flit.
// Define AIM_NOC_ALLOC_WATCHDOG_EN to add per-output stall watchdogs that force-release locks.
module aim_noc_switch_allocator #(
  parameter int unsigned WDOG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  req_valid,
  input  logic [14:0] req_port,
  input  logic [4:0]  req_tail,
  input  logic [4:0]  out_ready,
  output logic [4:0]  in_ready,
  output logic [4:0]  out_valid,
  output logic [14:0] xbar_sel,
  output logic        err_flag,
  output logic        wdog_flag
);

  localparam int unsigned NumPorts = 5;

  logic [4:0] owned_q, owned_d;
  logic [2:0] owner_q  [NumPorts];
  logic [2:0] owner_d  [NumPorts];
  logic [2:0] rr_ptr_q [NumPorts];
  logic [2:0] rr_ptr_d [NumPorts];
  logic       err_q, err_d;

`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q [NumPorts];
  logic [WDOG_W-1:0] wdog_cnt_d [NumPorts];
  logic              wdog_q, wdog_d;
`else
  logic unused_wdog_w;
  assign unused_wdog_w = ^WDOG_W;
`endif

  logic [2:0] port_sel  [NumPorts];
  logic [4:0] illegal;
  logic [4:0] owns_any;
  logic [4:0] eligible  [NumPorts];
  logic [4:0] grant_vld;
  logic [2:0] grant_idx [NumPorts];
  logic [4:0] xfer;
  logic [4:0] tail_xfer;

  // Request decode and the "already owns an output" mask.
  always_comb begin
    illegal  = '0;
    owns_any = '0;
    for (int i = 0; i < NumPorts; i++) begin
      port_sel[i] = req_port[3*i +: 3];
      illegal[i]  = req_valid[i] && (port_sel[i] > 3'd4);
    end
    for (int o = 0; o < NumPorts; o++) begin
      for (int i = 0; i < NumPorts; i++) begin
        if (owned_q[o] && (owner_q[o] == 3'(i))) begin
          owns_any[i] = 1'b1;
        end
      end
    end
    for (int o = 0; o < NumPorts; o++) begin
      eligible[o] = '0;
      for (int i = 0; i < NumPorts; i++) begin
        eligible[o][i] = req_valid[i] && (port_sel[i] == 3'(o)) && !owns_any[i];
      end
    end
  end

  // Round-robin search from rr_ptr upward, wrapping 4 -> 0; only free outputs arbitrate.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NumPorts; o++) begin
      grant_vld[o] = 1'b0;
      grant_idx[o] = 3'd0;
      if (!owned_q[o]) begin
        for (int k = 0; k < NumPorts; k++) begin
          idx = int'(rr_ptr_q[o]) + k;
          if (idx >= NumPorts) begin
            idx = idx - NumPorts;
          end
          if (!grant_vld[o] && eligible[o][idx]) begin
            grant_vld[o] = 1'b1;
            grant_idx[o] = 3'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NumPorts; o++) begin
      xfer[o]      = owned_q[o] && req_valid[owner_q[o]] && out_ready[o];
      tail_xfer[o] = xfer[o] && req_tail[owner_q[o]];
    end
  end

  always_comb begin
    owned_d = owned_q;
    err_d   = err_q | (|illegal);
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif
    for (int o = 0; o < NumPorts; o++) begin
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
      wdog_cnt_d[o] = wdog_cnt_q[o];
`endif
      if (owned_q[o]) begin
        // The freed output sits out one cycle, giving the inter-packet bubble.
        if (tail_xfer[o]) begin
          owned_d[o] = 1'b0;
        end
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
        if (xfer[o]) begin
          wdog_cnt_d[o] = '0;
        end else if (wdog_cnt_q[o] == {WDOG_W{1'b1}}) begin
          owned_d[o]    = 1'b0;
          wdog_cnt_d[o] = '0;
          wdog_d        = 1'b1;
        end else begin
          wdog_cnt_d[o] = wdog_cnt_q[o] + 1'b1;
        end
`endif
      end else if (grant_vld[o]) begin
        owned_d[o]  = 1'b1;
        owner_d[o]  = grant_idx[o];
        rr_ptr_d[o] = (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
        wdog_cnt_d[o] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owned_q <= '0;
      err_q   <= 1'b0;
      for (int o = 0; o < NumPorts; o++) begin
        owner_q[o]  <= 3'd0;
        rr_ptr_q[o] <= 3'd0;
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
        wdog_cnt_q[o] <= '0;
`endif
      end
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
      wdog_q <= 1'b0;
`endif
    end else begin
      owned_q <= owned_d;
      err_q   <= err_d;
      for (int o = 0; o < NumPorts; o++) begin
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
        wdog_cnt_q[o] <= wdog_cnt_d[o];
`endif
      end
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
      wdog_q <= wdog_d;
`endif
    end
  end

  // Crossbar controls follow the lock combinationally; forced idle while reset is high.
  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    xbar_sel  = '1;
    if (!reset) begin
      for (int o = 0; o < NumPorts; o++) begin
        if (owned_q[o]) begin
          out_valid[o]           = req_valid[owner_q[o]];
          in_ready[owner_q[o]]   = out_ready[o];
          xbar_sel[3*o +: 3]     = owner_q[o];
        end
      end
    end
  end

  assign err_flag = err_q;
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
  assign wdog_flag = wdog_q;
`else
  assign wdog_flag = 1'b0;
`endif

endmodule

// File: tb/tb_aim_noc_switch_allocator.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle outputs, a negedge monitor compares.
module tb_aim_noc_switch_allocator;

  localparam logic [4:0]  All1 = 5'b11111;
  localparam logic [14:0] Free = 15'h7FFF;

  logic        clk;
  logic        reset;
  logic [4:0]  req_valid;
  logic [14:0] req_port;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [4:0]  in_ready;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
  logic        err_flag;
  logic        wdog_flag;

  int checks = 0;
  int errors = 0;
  logic exp_wd = 1'b0;

  logic [26:0] sb_q [$];
  string       nm_q [$];

  aim_noc_switch_allocator #(
    .WDOG_W(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_port (req_port),
    .req_tail (req_tail),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .xbar_sel (xbar_sel),
    .err_flag (err_flag),
    .wdog_flag(wdog_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] fld(input int idx, input int val);
    logic [14:0] v;
    v = '0;
    v[3*idx +: 3] = 3'(val);
    return v;
  endfunction

  function automatic logic [14:0] xs(input int o, input int i);
    logic [14:0] v;
    v = Free;
    v[3*o +: 3] = 3'(i);
    return v;
  endfunction

  // Monitor: every pushed cycle is compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      logic [26:0] e;
      logic [26:0] a;
      string       n;
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      a = {in_ready, out_valid, xbar_sel, err_flag, wdog_flag};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ir=%b ov=%b xs=%h err=%b wd=%b, expected ir=%b ov=%b xs=%h err=%b wd=%b",
                 n, a[26:22], a[21:17], a[16:2], a[1], a[0],
                 e[26:22], e[21:17], e[16:2], e[1], e[0]);
      end
    end
  end

  task automatic cyc(input logic [4:0] rv, input logic [14:0] rp, input logic [4:0] rt,
                     input logic [4:0] ordy, input logic [4:0] e_ir, input logic [4:0] e_ov,
                     input logic [14:0] e_xs, input logic e_err, input string nm);
    req_valid = rv;
    req_port  = rp;
    req_tail  = rt;
    out_ready = ordy;
    sb_q.push_back({e_ir, e_ov, e_xs, e_err, exp_wd});
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    exp_wd = 1'b0;
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "reset");
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] rp;
    reset = 1'b1;
    req_valid = '0;
    req_port = '0;
    req_tail = '0;
    out_ready = All1;
    @(posedge clk);
    #1;
    do_reset();

    // Single 3-flit packet N -> L
    rp = fld(0, 4);
    cyc(5'b00001, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "sp_req");
    cyc(5'b00001, rp, 5'b0, All1, 5'b00001, 5'b10000, xs(4, 0), 1'b0, "sp_f1");
    cyc(5'b00001, rp, 5'b0, All1, 5'b00001, 5'b10000, xs(4, 0), 1'b0, "sp_f2");
    cyc(5'b00001, rp, 5'b00001, All1, 5'b00001, 5'b10000, xs(4, 0), 1'b0, "sp_f3_tail");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "sp_free");

    // Contention: three 1-flit packets to E, one bubble between grants
    rp = fld(0, 2) | fld(1, 2) | fld(2, 2);
    cyc(5'b00111, rp, 5'b00111, All1, 5'b0, 5'b0, Free, 1'b0, "ct_arb0");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b00001, 5'b00100, xs(2, 0), 1'b0, "ct_g0");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b0, 5'b0, Free, 1'b0, "ct_bub1");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b00010, 5'b00100, xs(2, 1), 1'b0, "ct_g1");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b0, 5'b0, Free, 1'b0, "ct_bub2");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b00100, 5'b00100, xs(2, 2), 1'b0, "ct_g2");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b0, 5'b0, Free, 1'b0, "ct_bub3");
    cyc(5'b00111, rp, 5'b00111, All1, 5'b00001, 5'b00100, xs(2, 0), 1'b0, "ct_g0_again");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "ct_free");

    // Backpressure W -> L, plus a mid-packet req_port change that must be ignored
    rp = fld(3, 4);
    cyc(5'b01000, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "bp_req");
    cyc(5'b01000, rp, 5'b0, All1, 5'b01000, 5'b10000, xs(4, 3), 1'b0, "bp_f1");
    cyc(5'b01000, rp, 5'b0, 5'b01111, 5'b0, 5'b10000, xs(4, 3), 1'b0, "bp_stall1");
    cyc(5'b01000, fld(3, 1), 5'b0, 5'b01111, 5'b0, 5'b10000, xs(4, 3), 1'b0, "bp_stall2_port_chg");
    cyc(5'b01000, rp, 5'b0, 5'b01111, 5'b0, 5'b10000, xs(4, 3), 1'b0, "bp_stall3");
    cyc(5'b01000, rp, 5'b0, All1, 5'b01000, 5'b10000, xs(4, 3), 1'b0, "bp_resume");
    cyc(5'b01000, rp, 5'b01000, All1, 5'b01000, 5'b10000, xs(4, 3), 1'b0, "bp_tail");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "bp_free");

    // Reset during flit 2 of S -> N; rr_ptr[4] must restart at 0 (3 beats 4)
    rp = fld(1, 0);
    cyc(5'b00010, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "rs_req");
    cyc(5'b00010, rp, 5'b0, All1, 5'b00010, 5'b00001, xs(0, 1), 1'b0, "rs_f1");
    reset = 1'b1;
    cyc(5'b00010, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "rs_in_reset");
    reset = 1'b0;
    rp = fld(1, 0) | fld(3, 4) | fld(4, 4);
    cyc(5'b11010, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "rs_rearb");
    cyc(5'b11010, rp, 5'b11010, All1, 5'b01010, 5'b10001, xs(0, 1) & xs(4, 3), 1'b0,
        "rs_regrant_dual");
    rp = fld(4, 4);
    cyc(5'b10000, rp, 5'b10000, All1, 5'b0, 5'b0, Free, 1'b0, "rs_bubble");
    cyc(5'b10000, rp, 5'b10000, All1, 5'b10000, 5'b10000, xs(4, 4), 1'b0, "rs_g4");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "rs_free");

    // Long stall E -> W: lock persists, or watchdog frees it after 16 stalled cycles
    rp = fld(2, 3);
    cyc(5'b00100, rp, 5'b0, 5'b10111, 5'b0, 5'b0, Free, 1'b0, "wd_req");
    for (int k = 1; k <= 20; k++) begin
      logic held;
`ifdef AIM_NOC_ALLOC_WATCHDOG_EN
      held   = (k <= 16) || (k >= 18);
      exp_wd = (k >= 17);
`else
      held   = 1'b1;
`endif
      if (held) begin
        cyc(5'b00100, rp, 5'b0, 5'b10111, 5'b0, 5'b01000, xs(3, 2), 1'b0, "wd_stall_held");
      end else begin
        cyc(5'b00100, rp, 5'b0, 5'b10111, 5'b0, 5'b0, Free, 1'b0, "wd_stall_freed");
      end
    end
    cyc(5'b00100, rp, 5'b00100, All1, 5'b00100, 5'b01000, xs(3, 2), 1'b0, "wd_tail");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "wd_free");

    // Illegal req_port = 6: no grant, sticky err_flag until reset
    rp = fld(0, 6);
    cyc(5'b00001, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "il_req");
    cyc(5'b00001, rp, 5'b0, All1, 5'b0, 5'b0, Free, 1'b1, "il_err_set");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b1, "il_err_sticky1");
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b1, "il_err_sticky2");
    do_reset();
    cyc(5'b0, 15'b0, 5'b0, All1, 5'b0, 5'b0, Free, 1'b0, "post_reset_idle");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
